control_ascensor: RTL and testbench
===================================

CONTROL_ASCENSOR -- requirements
Module: control_ascensor

Interface
REQ-001 SHALL have parameter T_PISO, default 8, meaning clock cycles of travel between adjacent floors (legal range 2..255).
REQ-002 SHALL have parameter T_PUERTA, default 6, meaning clock cycles the door stays open (legal range 2..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port memoria  input  4  next-instruction code from the request memory.
REQ-006 SHALL have port obstaculo  input  1  door obstruction; holds the door open.
REQ-007 SHALL have port piso  output  2  current floor; 0 = floor 1 through 3 = floor 4.
REQ-008 SHALL have port accion  output  2  motion: 0 = stopped, 1 = up, 2 = down; 3 never driven.
REQ-009 SHALL have port puertas  output  1  door state: 1 = open, 0 = closed.
REQ-010 SHALL have port consulta  output  1  single-cycle strobe telling the request memory to re-evaluate and clear served requests.

Function
REQ-011 SHALL decode memoria to a target floor:
  - codes 1 and 5 -> 0
  - codes 2, 6 and 7 -> 1
  - codes 3, 8 and 9 -> 2
  - codes 4 and 10 -> 3
  - codes 0 and 11..15 -> no target.
REQ-012 SHALL implement four states: REPOSO, SUBIENDO, BAJANDO and PUERTA_ABIERTA.
REQ-013 SHALL drive all outputs from registers, so any decision appears one cycle after memoria is sampled.
REQ-014 In REPOSO with no target, SHALL stay in REPOSO with accion = 0 and puertas = 0.
REQ-015 In REPOSO, target == piso SHALL cause PUERTA_ABIERTA with puertas = 1.
REQ-016 In REPOSO, target > piso SHALL cause SUBIENDO with accion = 1; target < piso SHALL cause BAJANDO with accion = 2.
REQ-017 In SUBIENDO and BAJANDO, a travel counter SHALL count T_PISO cycles.
REQ-018 On terminal count, piso SHALL step by ±1, the counter SHALL clear, and consulta SHALL pulse for 1 cycle.
REQ-019 On each arrival, memoria SHALL be sampled on the cycle after the consulta pulse:
  - target == piso -> accion = 0, enter PUERTA_ABIERTA
  - target further in the travel direction -> continue moving
  - no target or target in the opposite direction -> accion = 0, enter REPOSO with puertas = 0.
REQ-020 piso SHALL never wrap: SUBIENDO at piso = 3 and BAJANDO at piso = 0 SHALL force REPOSO, regardless of memoria.
REQ-021 PUERTA_ABIERTA SHALL count T_PUERTA cycles and reload its counter on every cycle obstaculo = 1.
REQ-022 At PUERTA_ABIERTA terminal count, puertas SHALL go to 0, consulta SHALL pulse for 1 cycle, and the state SHALL go to REPOSO.
REQ-023 consulta SHALL also pulse for 1 cycle on every REPOSO -> SUBIENDO/BAJANDO transition.
REQ-024 accion and puertas SHALL never both be non-zero: the door opens only when stopped.
REQ-025 A memoria change during travel SHALL take effect only at the next floor arrival; there is no mid-floor reversal.
REQ-026 If obstaculo = 1 outside PUERTA_ABIERTA, it SHALL be ignored.

Reset
REQ-027 Asserting rst SHALL immediately force:
  - state REPOSO
  - piso = 0, accion = 0, puertas = 0, consulta = 0
  - both counters = 0.
REQ-028 Reset mid-travel or with the door open SHALL abandon the operation; there is no resume after rst deasserts.
REQ-029 The first decision after rst deasserts SHALL occur on the second rising clk edge.

Structure
REQ-030 Package ascensor_pkg SHALL hold:
  - the state encoding
  - the accion codes (PARADO = 0, SUBE = 1, BAJA = 2)
  - the request-code constants 1..10
  - the floor constants.
REQ-031 The memoria-to-floor mapping SHALL be a combinational sub-module decodificador_destino with outputs destino[1:0] and valido.
REQ-032 A single shared 8-bit counter SHALL serve both travel and door timing.

Verification
REQ-033 Reset, then memoria = 4 held, defaults -> accion = 1 for 3×8 cycles with piso stepping 0→1→2→3, then accion = 0 and puertas = 1 for 6 cycles, with consulta pulses at each arrival and at door close.
REQ-034 From piso = 3 idle, memoria = 5 -> accion = 2 and piso descends to 0, then puertas = 1; switching memoria to 6 while passing floor 2 mid-travel -> stop at piso = 1 on the next arrival with the door open.
REQ-035 Door open, obstaculo held for 20 cycles -> puertas stays 1 for the full 20 cycles plus 6 more, then closes with one consulta pulse.
REQ-036 Idle at piso = 2, memoria = 9 -> door opens without movement; memoria = 0 or 12 -> no state change and no consulta.
REQ-037 rst asserted mid-travel at piso = 1 -> all outputs read 0 within the same cycle without a clock edge; after release with memoria = 0 -> remains in REPOSO.
REQ-038 Moving up with memoria = 1 at arrival -> stops in REPOSO with accion = 0 and puertas = 0; next cycle -> BAJANDO.

Source files
------------

// File: rtl/ascensor_pkg.sv
// ascensor_pkg -- shared definitions for the four-floor elevator controller.
//   estado_t        : controller state encoding
//   PARADO/SUBE/BAJA: codes driven on accion
//   COD_1..COD_10   : request codes delivered by the request memory
//   PISO_1..PISO_4  : floor numbers as seen on piso
//   CNT_W           : width of the shared travel/door counter
package ascensor_pkg;

  typedef enum logic [1:0] {
    REPOSO         = 2'd0,
    SUBIENDO       = 2'd1,
    BAJANDO        = 2'd2,
    PUERTA_ABIERTA = 2'd3
  } estado_t;

  localparam logic [1:0] PARADO = 2'd0;
  localparam logic [1:0] SUBE   = 2'd1;
  localparam logic [1:0] BAJA   = 2'd2;

  localparam logic [3:0] COD_1  = 4'd1;
  localparam logic [3:0] COD_2  = 4'd2;
  localparam logic [3:0] COD_3  = 4'd3;
  localparam logic [3:0] COD_4  = 4'd4;
  localparam logic [3:0] COD_5  = 4'd5;
  localparam logic [3:0] COD_6  = 4'd6;
  localparam logic [3:0] COD_7  = 4'd7;
  localparam logic [3:0] COD_8  = 4'd8;
  localparam logic [3:0] COD_9  = 4'd9;
  localparam logic [3:0] COD_10 = 4'd10;

  localparam logic [1:0] PISO_1 = 2'd0;
  localparam logic [1:0] PISO_2 = 2'd1;
  localparam logic [1:0] PISO_3 = 2'd2;
  localparam logic [1:0] PISO_4 = 2'd3;

  localparam int CNT_W = 8;

endpackage

// File: rtl/decodificador_destino.sv
// decodificador_destino -- combinational map from a request-memory code to a
// target floor.
//   memoria : request code (0 and 11..15 carry no request)
//   destino : target floor, 0 = floor 1 .. 3 = floor 4 (0 when not valido)
//   valido  : 1 when memoria names a floor
module decodificador_destino
  import ascensor_pkg::*;
(
  input  logic [3:0] memoria,
  output logic [1:0] destino,
  output logic       valido
);

  always_comb begin
    destino = PISO_1;
    valido  = 1'b0;
    case (memoria)
      COD_1, COD_5:         begin destino = PISO_1; valido = 1'b1; end
      COD_2, COD_6, COD_7:  begin destino = PISO_2; valido = 1'b1; end
      COD_3, COD_8, COD_9:  begin destino = PISO_3; valido = 1'b1; end
      COD_4, COD_10:        begin destino = PISO_4; valido = 1'b1; end
      default:              begin destino = PISO_1; valido = 1'b0; end
    endcase
  end

endmodule

// File: rtl/control_ascensor.sv
// control_ascensor -- four-floor elevator controller.
//   clk       : sole clock, rising edge
//   rst       : asynchronous active-high reset
//   memoria   : next-instruction code from the request memory
//   obstaculo : door obstruction, holds an open door open
//   piso      : current floor (0 = floor 1 .. 3 = floor 4)
//   accion    : 0 stopped, 1 up, 2 down
//   puertas   : 1 door open
//   consulta  : one-cycle strobe asking the request memory to re-evaluate
// All outputs are registers. One counter times both floor travel and door
// dwell. After each floor arrival the controller spends one cycle letting the
// request memory react to consulta, then samples memoria on the next edge;
// travel timing keeps running through that cycle so floors stay T_PISO apart.
module control_ascensor
  import ascensor_pkg::*;
#(
  parameter int T_PISO   = 8,
  parameter int T_PUERTA = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] memoria,
  input  logic       obstaculo,
  output logic [1:0] piso,
  output logic [1:0] accion,
  output logic       puertas,
  output logic       consulta
);

  localparam logic [CNT_W-1:0] FIN_PISO   = 8'(T_PISO - 1);
  localparam logic [CNT_W-1:0] FIN_PUERTA = 8'(T_PUERTA - 1);

  estado_t          estado, estado_sig;
  logic [CNT_W-1:0] cnt, cnt_sig;
  logic             evalua, evalua_sig;
  logic             arranque;
  logic [1:0]       piso_sig, accion_sig;
  logic             puertas_sig, consulta_sig;
  logic [1:0]       destino;
  logic             valido;
  logic             sigue, en_tope;

  decodificador_destino u_dec (
    .memoria (memoria),
    .destino (destino),
    .valido  (valido)
  );

  // arranque holds off decisions for the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= REPOSO;
      cnt      <= '0;
      evalua   <= 1'b0;
      arranque <= 1'b0;
      piso     <= PISO_1;
      accion   <= PARADO;
      puertas  <= 1'b0;
      consulta <= 1'b0;
    end else begin
      estado   <= estado_sig;
      cnt      <= cnt_sig;
      evalua   <= evalua_sig;
      arranque <= 1'b1;
      piso     <= piso_sig;
      accion   <= accion_sig;
      puertas  <= puertas_sig;
      consulta <= consulta_sig;
    end
  end

  // target lies further along the current travel direction
  assign sigue   = (estado == SUBIENDO) ? (destino > piso) : (destino < piso);
  // no floor left in the travel direction
  assign en_tope = ((estado == SUBIENDO) && (piso == PISO_4)) ||
                   ((estado == BAJANDO)  && (piso == PISO_1));

  always_comb begin
    estado_sig   = estado;
    cnt_sig      = cnt;
    evalua_sig   = 1'b0;
    piso_sig     = piso;
    accion_sig   = accion;
    puertas_sig  = puertas;
    consulta_sig = 1'b0;
    case (estado)
      REPOSO: begin
        accion_sig  = PARADO;
        puertas_sig = 1'b0;
        cnt_sig     = '0;
        if (arranque && valido) begin
          if (destino == piso) begin
            estado_sig  = PUERTA_ABIERTA;
            puertas_sig = 1'b1;
          end else if (destino > piso) begin
            estado_sig   = SUBIENDO;
            accion_sig   = SUBE;
            consulta_sig = 1'b1;
          end else begin
            estado_sig   = BAJANDO;
            accion_sig   = BAJA;
            consulta_sig = 1'b1;
          end
        end
      end
      SUBIENDO, BAJANDO: begin
        cnt_sig = cnt + 8'd1;
        if (evalua) begin
          if (valido && (destino == piso)) begin
            estado_sig  = PUERTA_ABIERTA;
            accion_sig  = PARADO;
            puertas_sig = 1'b1;
            cnt_sig     = '0;
          end else if (!(valido && sigue) || en_tope) begin
            estado_sig = REPOSO;
            accion_sig = PARADO;
            cnt_sig    = '0;
          end
        end else if (cnt == FIN_PISO) begin
          cnt_sig = '0;
          if (en_tope) begin
            estado_sig = REPOSO;
            accion_sig = PARADO;
          end else begin
            piso_sig     = (estado == SUBIENDO) ? piso + 2'd1 : piso - 2'd1;
            consulta_sig = 1'b1;
            evalua_sig   = 1'b1;
          end
        end
      end
      PUERTA_ABIERTA: begin
        accion_sig = PARADO;
        if (obstaculo) begin
          cnt_sig = '0;
        end else if (cnt == FIN_PUERTA) begin
          estado_sig   = REPOSO;
          puertas_sig  = 1'b0;
          consulta_sig = 1'b1;
          cnt_sig      = '0;
        end else begin
          cnt_sig = cnt + 8'd1;
        end
      end
      default: begin
        estado_sig = REPOSO;
        accion_sig = PARADO;
        cnt_sig    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_ascensor.sv
// tb_control_ascensor -- directed bench for control_ascensor with default
// timing (T_PISO = 8, T_PUERTA = 6). Outputs are checked 1 time unit after
// each rising edge; expected values are written out by hand per step.
module tb_control_ascensor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] memoria = 4'd0;
  logic       obstaculo = 1'b0;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       puertas;
  logic       consulta;

  int n_cmp = 0;
  int n_err = 0;

  control_ascensor #(.T_PISO(8), .T_PUERTA(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .memoria   (memoria),
    .obstaculo (obstaculo),
    .piso      (piso),
    .accion    (accion),
    .puertas   (puertas),
    .consulta  (consulta)
  );

  always #5 clk = ~clk;

  task automatic ver(input string tag, input int p, input int a, input int d, input int c);
    logic [5:0] obs;
    logic [5:0] esp;
    obs = {piso, accion, puertas, consulta};
    esp = {2'(p), 2'(a), 1'(d), 1'(c)};
    n_cmp++;
    assert (obs === esp) else begin
      n_err++;
      $error("FAIL %s: observed piso=%0d accion=%0d puertas=%0d consulta=%0d, expected piso=%0d accion=%0d puertas=%0d consulta=%0d",
             tag, piso, accion, puertas, consulta, p, a, d, c);
    end
  endtask

  task automatic nx(input string tag, input int p, input int a, input int d, input int c);
    @(posedge clk);
    #1;
    ver(tag, p, a, d, c);
  endtask

  task automatic viaje(input string tag, input int p, input int a, input int n);
    repeat (n) nx(tag, p, a, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #1 ver("reset_async", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    memoria = 4'd4;

    // full climb 0 -> 3 and door at floor 4
    nx("arranque", 0, 0, 0, 0);
    nx("sale_sube", 0, 1, 0, 1);
    viaje("sube_p1", 0, 1, 7); nx("llega_p2", 1, 1, 0, 1);
    viaje("sube_p2", 1, 1, 7); nx("llega_p3", 2, 1, 0, 1);
    viaje("sube_p3", 2, 1, 7); nx("llega_p4", 3, 1, 0, 1);
    nx("abre_p4", 3, 0, 1, 0);
    repeat (5) nx("puerta_p4", 3, 0, 1, 0);
    nx("cierra_p4", 3, 0, 0, 1);
    memoria = 4'd0;
    nx("reposo_p4", 3, 0, 0, 0);

    // descend with target changed mid-leg, stop at floor 2
    memoria = 4'd5;
    nx("sale_baja", 3, 2, 0, 1);
    viaje("baja_p4", 3, 2, 7); nx("llega_p3b", 2, 2, 0, 1);
    viaje("baja_p3a", 2, 2, 3);
    memoria = 4'd6;
    viaje("baja_p3b", 2, 2, 4);
    nx("llega_p2b", 1, 2, 0, 1);
    nx("abre_p2", 1, 0, 1, 0);
    repeat (5) nx("puerta_p2", 1, 0, 1, 0);
    nx("cierra_p2", 1, 0, 0, 1);

    // down to floor 1, door held by the obstruction
    memoria = 4'd1;
    nx("sale_baja_p1", 1, 2, 0, 1);
    viaje("baja_p2", 1, 2, 7); nx("llega_p1", 0, 2, 0, 1);
    nx("abre_p1", 0, 0, 1, 0);
    obstaculo = 1'b1;
    repeat (20) nx("obstaculo", 0, 0, 1, 0);
    obstaculo = 1'b0;
    repeat (5) nx("puerta_p1", 0, 0, 1, 0);
    nx("cierra_p1", 0, 0, 0, 1);
    memoria = 4'd0;
    obstaculo = 1'b1;
    repeat (2) nx("ignora_obst", 0, 0, 0, 0);
    obstaculo = 1'b0;

    // climb to floor 3 with obstruction ignored while moving
    memoria = 4'd3;
    nx("sale_q", 0, 1, 0, 1);
    obstaculo = 1'b1;
    viaje("sube_obst", 0, 1, 7); nx("llega_q2", 1, 1, 0, 1);
    viaje("sube_q2", 1, 1, 7); nx("llega_q3", 2, 1, 0, 1);
    obstaculo = 1'b0;
    nx("abre_q3", 2, 0, 1, 0);
    repeat (5) nx("puerta_q3", 2, 0, 1, 0);
    nx("cierra_q3", 2, 0, 0, 1);

    // idle at floor 3: no-target codes do nothing, code 9 opens in place
    memoria = 4'd0;
    repeat (2) nx("idle_0", 2, 0, 0, 0);
    memoria = 4'd12;
    repeat (2) nx("idle_12", 2, 0, 0, 0);
    memoria = 4'd9;
    nx("abre_9", 2, 0, 1, 0);
    memoria = 4'd0;
    repeat (5) nx("puerta_9", 2, 0, 1, 0);
    nx("cierra_9", 2, 0, 0, 1);

    // reset while travelling down past floor 2
    memoria = 4'd1;
    nx("sale_r", 2, 2, 0, 1);
    viaje("baja_r", 2, 2, 7); nx("llega_r", 1, 2, 0, 1);
    nx("sigue_r", 1, 2, 0, 0);
    #2 rst = 1'b1;
    #1 ver("rst_viaje", 0, 0, 0, 0);
    memoria = 4'd0;
    @(posedge clk); #1;
    ver("rst_sostenido", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (3) nx("tras_rst", 0, 0, 0, 0);

    // opposite-direction request on arrival: stop, then reverse
    memoria = 4'd3;
    nx("sale_s", 0, 1, 0, 1);
    viaje("sube_s", 0, 1, 7); nx("llega_s", 1, 1, 0, 1);
    memoria = 4'd1;
    nx("para_s", 1, 0, 0, 0);
    nx("invierte_s", 1, 2, 0, 1);
    viaje("baja_s", 1, 2, 7); nx("llega_s0", 0, 2, 0, 1);
    memoria = 4'd0;
    nx("reposo_s0", 0, 0, 0, 0);
    nx("quieto_s0", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
